// File: rtl/step_phase_decoder_if.sv
// Stepper coil-line interface: coil drive pattern and distance clear towards
// the decoder, decoded step/distance status back to the fare logic.
interface step_phase_decoder_if;
    logic [3:0]  step_in;
    logic        clr_dist;
    logic        step_pulse;
    logic        dir;
    logic        phase_err;
    logic        dist_pulse;
    logic [15:0] dist_cnt;
    logic        moving;

    // Drive side (coil driver / fare logic).
    modport master (
        output step_in, clr_dist,
        input  step_pulse, dir, phase_err, dist_pulse, dist_cnt, moving
    );

    // Receiving side (the decoder).
    modport slave (
        input  step_in, clr_dist,
        output step_pulse, dir, phase_err, dist_pulse, dist_cnt, moving
    );
endinterface

// File: rtl/step_phase_decoder.sv
// Half-step stepper phase decoder: synchronizes and glitch-filters the coil
// pattern, decodes the 8-position half-step ring into forward/reverse steps,
// flags illegal codes and jumps, accumulates net forward steps into distance
// units and tracks whether the motor is still moving.
module step_phase_decoder #(
    parameter logic [7:0]  STABLE_CYC     = 8'd4,
    parameter logic [15:0] STEPS_PER_UNIT = 16'd400,
    parameter logic [23:0] TIMEOUT        = 24'd9_999_999
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    step_phase_decoder_if.slave   bus
);

    localparam logic [7:0]  STAB_LAST = STABLE_CYC - 8'd1;
    localparam logic [15:0] ACC_LAST  = STEPS_PER_UNIT - 16'd1;

    typedef enum logic [1:0] {
        CLS_IDLE,
        CLS_VALID,
        CLS_ILLEGAL
    } code_cls_e;

    typedef struct packed {
        code_cls_e  cls;
        logic [2:0] idx;
    } code_info_t;

    logic [3:0]  sync_1;
    logic [3:0]  step_s;
    logic [3:0]  cand;
    logic [7:0]  stab_cnt;
    logic [3:0]  acc_code;
    logic        idx_valid;
    logic [2:0]  p_idx;
    logic [15:0] step_acc;
    logic [23:0] tmo_cnt;

    logic        step_pulse_q;
    logic        dir_q;
    logic        phase_err_q;
    logic        dist_pulse_q;
    logic [15:0] dist_cnt_q;
    logic        moving_q;

    code_info_t  cand_info;
    logic        accept;
    logic        seq_check;
    logic        fwd_step;
    logic        rev_step;
    logic        bad_step;
    logic [2:0]  p_next;
    logic [2:0]  p_prev;

    // Two-flop synchronizer for the asynchronous coil lines.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the two stages into one.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_1 <= 4'b0000;
            step_s <= 4'b0000;
        end else begin
            sync_1 <= bus.step_in;
            step_s <= sync_1;
        end
    end

    // Glitch filter: a code must hold STABLE_CYC cycles before it is accepted.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cand     <= 4'b0000;
            stab_cnt <= 8'd0;
            acc_code <= 4'b0000;
        end else begin
            if (step_s != cand) begin
                cand     <= step_s;
                stab_cnt <= 8'd0;
            end else if (stab_cnt != STAB_LAST) begin
                stab_cnt <= stab_cnt + 8'd1;
            end
            if (accept) begin
                acc_code <= cand;
            end
        end
    end

    // Map the candidate code onto its half-step ring position.
    // NOTE: give every always_comb output a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cand_info.cls = CLS_VALID;
        cand_info.idx = 3'd0;
        case (cand)
            4'b0000: cand_info.cls = CLS_IDLE;
            4'b0001: cand_info.idx = 3'd0;
            4'b0011: cand_info.idx = 3'd1;
            4'b0010: cand_info.idx = 3'd2;
            4'b0110: cand_info.idx = 3'd3;
            4'b0100: cand_info.idx = 3'd4;
            4'b1100: cand_info.idx = 3'd5;
            4'b1000: cand_info.idx = 3'd6;
            4'b1001: cand_info.idx = 3'd7;
            default: cand_info.cls = CLS_ILLEGAL;
        endcase
    end

    // Ring neighbours wrap naturally in 3-bit arithmetic.
    assign p_next    = p_idx + 3'd1;
    assign p_prev    = p_idx - 3'd1;
    assign accept    = (step_s == cand) && (stab_cnt == STAB_LAST) && (cand != acc_code);
    assign seq_check = accept && (cand_info.cls == CLS_VALID) && idx_valid;
    assign fwd_step  = seq_check && (cand_info.idx == p_next);
    assign rev_step  = seq_check && (cand_info.idx == p_prev);
    assign bad_step  = (accept && (cand_info.cls == CLS_ILLEGAL))
                     || (seq_check && !fwd_step && !rev_step);

    // Phase tracking: ring position, direction and step/error pulses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx_valid    <= 1'b0;
            p_idx        <= 3'd0;
            step_pulse_q <= 1'b0;
            phase_err_q  <= 1'b0;
            dir_q        <= 1'b0;
        end else begin
            step_pulse_q <= fwd_step | rev_step;
            phase_err_q  <= bad_step;
            if (fwd_step) begin
                dir_q <= 1'b1;
            end else if (rev_step) begin
                dir_q <= 1'b0;
            end
            // Any accepted valid code becomes the new reference position,
            // including after a jump (resync); idle and illegal drop the lock.
            if (accept) begin
                if (cand_info.cls == CLS_VALID) begin
                    p_idx     <= cand_info.idx;
                    idx_valid <= 1'b1;
                end else begin
                    idx_valid <= 1'b0;
                end
            end
        end
    end

    // Distance accumulation; a clear overrides any step in the same cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            step_acc     <= 16'd0;
            dist_cnt_q   <= 16'd0;
            dist_pulse_q <= 1'b0;
        end else begin
            dist_pulse_q <= 1'b0;
            if (bus.clr_dist) begin
                step_acc   <= 16'd0;
                dist_cnt_q <= 16'd0;
            end else if (fwd_step) begin
                if (step_acc == ACC_LAST) begin
                    step_acc     <= 16'd0;
                    dist_pulse_q <= 1'b1;
                    if (dist_cnt_q != 16'hFFFF) begin
                        dist_cnt_q <= dist_cnt_q + 16'd1;
                    end
                end else begin
                    step_acc <= step_acc + 16'd1;
                end
            end else if (rev_step && (step_acc != 16'd0)) begin
                // Reverse motion only unwinds the partial unit, never dist_cnt.
                step_acc <= step_acc - 16'd1;
            end
        end
    end

    // Motion timeout: moving stays high until TIMEOUT cycles pass without a step.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            moving_q <= 1'b0;
            tmo_cnt  <= 24'd0;
        end else if (fwd_step || rev_step) begin
            moving_q <= 1'b1;
            tmo_cnt  <= 24'd0;
        end else if (moving_q) begin
            if (tmo_cnt == TIMEOUT) begin
                moving_q <= 1'b0;
                tmo_cnt  <= 24'd0;
            end else begin
                tmo_cnt <= tmo_cnt + 24'd1;
            end
        end
    end

    assign bus.step_pulse = step_pulse_q;
    assign bus.dir        = dir_q;
    assign bus.phase_err  = phase_err_q;
    assign bus.dist_pulse = dist_pulse_q;
    assign bus.dist_cnt   = dist_cnt_q;
    assign bus.moving     = moving_q;

endmodule

// File: tb/tb_step_phase_decoder.sv
// Self-checking bench for step_phase_decoder: directed scenarios followed by
// randomized coil sequences, all compared against a ring-position model.
module tb_step_phase_decoder;

    localparam int STABLE = 2;
    localparam int SPU    = 4;
    localparam int TMO    = 50;
    localparam int LAT    = 2 + STABLE + 1;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    step_phase_decoder_if bus ();

    step_phase_decoder #(
        .STABLE_CYC    (8'(STABLE)),
        .STEPS_PER_UNIT(16'(SPU)),
        .TIMEOUT       (24'(TMO))
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int n_step, n_err, n_dist, first_k;

    // Reference model: ring position, direction, partial and whole units.
    logic [3:0] ring [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                             4'b0100, 4'b1100, 4'b1000, 4'b1001};
    bit         m_valid, m_dir, m_had;
    int         m_pos, m_acc, m_dist, m_since;
    logic [3:0] m_code;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int code_index(input logic [3:0] c);
        for (int i = 0; i < 8; i++) if (ring[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_dir = 0; m_had = 0;
        m_pos = 0; m_acc = 0; m_dist = 0; m_since = 0;
        m_code = 4'b0000;
    endtask

    // One clock; check per-cycle outputs and the motion timeout model.
    task automatic tick_check(input bit e_step, input bit e_err, input bit e_dp);
        @(negedge sys_clk);
        if (e_step) begin
            m_had = 1; m_since = 0;
        end else if (m_had) begin
            m_since++;
        end
        check("step_pulse", bus.step_pulse, e_step);
        check("phase_err",  bus.phase_err,  e_err);
        check("dist_pulse", bus.dist_pulse, e_dp);
        check("moving",     bus.moving,     m_had && (m_since <= TMO));
        check("exclusive",  bus.step_pulse & bus.phase_err, 0);
        if (bus.step_pulse === 1'b1) n_step++;
        if (bus.phase_err === 1'b1)  n_err++;
        if (bus.dist_pulse === 1'b1) n_dist++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick_check(0, 0, 0);
    endtask

    // Drive a code for 'hold' cycles; optionally clear distance on the edge
    // where that code gets accepted.
    task automatic drive(input logic [3:0] code, input int hold, input bit clr);
        bit e_step = 0, e_err = 0, e_dp = 0, fwd = 0, rev = 0;
        int idx, d;
        if (code != m_code) begin
            m_code = code;
            idx = code_index(code);
            if (code == 4'b0000) begin
                m_valid = 0;
            end else if (idx < 0) begin
                e_err = 1; m_valid = 0;
            end else if (!m_valid) begin
                m_valid = 1; m_pos = idx;
            end else begin
                d = (idx - m_pos + 8) % 8;
                if (d == 1)      begin fwd = 1; m_dir = 1; end
                else if (d == 7) begin rev = 1; m_dir = 0; end
                else             e_err = 1;
                e_step = fwd | rev;
                m_pos = idx;
            end
        end
        if (clr) begin
            m_acc = 0; m_dist = 0;
        end else if (fwd) begin
            if (m_acc == SPU - 1) begin
                m_acc = 0; e_dp = 1;
                if (m_dist < 65535) m_dist++;
            end else begin
                m_acc++;
            end
        end else if (rev && m_acc > 0) begin
            m_acc--;
        end
        bus.step_in = code;
        first_k = 0;
        for (int k = 1; k <= hold; k++) begin
            tick_check(k == LAT && e_step, k == LAT && e_err, k == LAT && e_dp);
            if (bus.step_pulse === 1'b1 && first_k == 0) first_k = k;
            bus.clr_dist = (clr && k == LAT - 1);
        end
        check("dir",      bus.dir,      m_dir);
        check("dist_cnt", bus.dist_cnt, m_dist);
    endtask

    // Short excursion away from the steady code, then back.
    task automatic glitch(input logic [3:0] g, input int len);
        bus.step_in = g;
        for (int i = 0; i < len; i++) tick_check(0, 0, 0);
        bus.step_in = m_code;
        idle(10);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_step"},   bus.step_pulse, 0);
        check({tag, "_dir"},    bus.dir,        0);
        check({tag, "_err"},    bus.phase_err,  0);
        check({tag, "_dpulse"}, bus.dist_pulse, 0);
        check({tag, "_dcnt"},   bus.dist_cnt,   0);
        check({tag, "_moving"}, bus.moving,     0);
    endtask

    initial begin
        logic [3:0] nxt;
        int hold;
        bit clr;

        bus.step_in  = 4'b0000;
        bus.clr_dist = 1'b0;
        model_reset();
        repeat (2) @(negedge sys_clk);
        check_all_zero("reset");
        sys_rst_n = 1'b1;
        idle(3);

        // 1: acquire, then one forward step at the expected latency.
        n_step = 0;
        drive(4'b0001, 10, 0);
        check("t1_acquire_steps", n_step, 0);
        drive(4'b0011, 10, 0);
        check("t1_steps", n_step, 1);
        check("t1_latency", first_k, 5);
        check("t1_dir", bus.dir, 1);

        // 2: clean accumulator, one full ring forward.
        drive(4'b0000, 10, 1);
        drive(4'b0001, 10, 0);
        n_step = 0; n_dist = 0;
        for (int i = 1; i <= 8; i++) drive(ring[i % 8], 10, 0);
        check("t2_steps", n_step, 8);
        check("t2_dist_pulses", n_dist, 2);
        check("t2_dist_cnt", bus.dist_cnt, 2);

        // 3: reverse steps from an acquired 0110; accumulator floors at 0.
        drive(4'b0000, 10, 0);
        drive(4'b0110, 10, 0);
        n_step = 0; n_dist = 0;
        drive(4'b0010, 10, 0);
        drive(4'b0011, 10, 0);
        check("t3_steps", n_step, 2);
        check("t3_dir", bus.dir, 0);
        check("t3_dist_cnt", bus.dist_cnt, 2);

        // 4: jump and illegal code, then re-acquire through idle.
        drive(4'b0001, 10, 0);
        n_step = 0; n_err = 0;
        drive(4'b0100, 10, 0);
        drive(4'b0111, 10, 0);
        drive(4'b0000, 10, 0);
        drive(4'b0001, 10, 0);
        check("t4_errors", n_err, 2);
        check("t4_steps", n_step, 0);

        // 5: short glitches inside a steady code are rejected.
        n_step = 0; n_err = 0;
        glitch(4'b0011, 1);
        glitch(4'b0011, 2);
        check("t5_steps", n_step, 0);
        check("t5_errors", n_err, 0);

        // 6: clear coincident with a step, timeout, reset mid-sequence.
        drive(4'b0011, 10, 0);
        drive(4'b0010, 10, 0);
        drive(4'b0110, 10, 0);
        n_step = 0; n_dist = 0;
        drive(4'b0100, 10, 1);
        check("t6_clr_step", n_step, 1);
        check("t6_clr_dpulse", n_dist, 0);
        check("t6_clr_dcnt", bus.dist_cnt, 0);
        idle(40);
        check("t6_moving_hi", bus.moving, 1);
        idle(10);
        check("t6_moving_lo", bus.moving, 0);
        drive(4'b1100, 10, 0);
        drive(4'b1000, 10, 0);
        drive(4'b1001, 10, 0);
        drive(4'b0001, 10, 0);
        check("t6_dcnt_before_rst", bus.dist_cnt, 1);
        bus.step_in = 4'b0011;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        bus.step_in = 4'b0000;
        model_reset();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle(3);
        n_step = 0;
        drive(4'b0001, 10, 0);
        check("t6_reacquire", n_step, 0);
        drive(4'b0011, 10, 0);
        check("t6_after_rst_step", n_step, 1);

        // Randomized coil sequences: mostly neighbours, some jumps/illegal/idle.
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: nxt = ring[(m_pos + 1) % 8];
                4, 5, 6:    nxt = ring[(m_pos + 7) % 8];
                7:          nxt = 4'($urandom_range(0, 15));
                8:          nxt = 4'b0000;
                default:    nxt = ring[$urandom_range(0, 7)];
            endcase
            hold = ($urandom_range(0, 7) == 0) ? 70 : int'($urandom_range(6, 20));
            clr  = ($urandom_range(0, 9) == 0);
            drive(nxt, hold, clr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/step_phase_decoder.md
Name: step_phase_decoder

Overview:
- Monitors the 4-phase half-step drive pattern on the stepper coil lines (A=bit0, B=bit1, C=bit2, D=bit3) and decodes phase sequence into step events and direction.
- Accumulates net forward half-steps into distance units and counts them for the fare logic.
- Sits between the motor coil lines and the fare/distance accounting; it is the receiving end of the stepper drive interface.

Parameters:
- STABLE_CYC, 8'd4: consecutive cycles a synchronized code must hold before it is accepted (glitch filter); legal range 1..255.
- STEPS_PER_UNIT, 16'd400: net forward half-steps per distance unit.
- TIMEOUT, 24'd9_999_999: cycles without an accepted step before `moving` drops.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset; asynchronous, active-low.
- step_in  in  4  coil drive pattern, asynchronous to sys_clk.
- clr_dist  in  1  synchronous clear of distance state; active high.
- step_pulse  out  1  one-cycle pulse per accepted valid half-step, either direction.
- dir  out  1  direction of last valid step; 1 = forward (A→AB→B→…→DA→A), 0 = reverse.
- phase_err  out  1  one-cycle pulse on an illegal transition or an illegal code.
- dist_pulse  out  1  one-cycle pulse when a distance unit completes.
- dist_cnt  out  16  completed distance units; saturates at 16'hFFFF.
- moving  out  1  high while steps arrive within TIMEOUT cycles.

Behaviour:
- **Reset:** all outputs 0. Internal state is cleared: sync flops 0, accepted code 4'b0000, index-valid flag 0, step_acc 0, stability and timeout counters 0.
- **Input synchronization:** step_in passes through a 2-flop synchronizer, giving step_s.
- **Glitch filter:**
  - Candidate register cand and counter stab_cnt.
  - If step_s != cand: cand <= step_s, stab_cnt <= 0.
  - Else if stab_cnt != STABLE_CYC-1: stab_cnt increments.
  - On the cycle step_s == cand and stab_cnt == STABLE_CYC-1, cand is accepted if it differs from the current accepted code.
  - Outputs for that acceptance are registered next cycle. Total latency from step_in edge to step_pulse/phase_err = 2 + STABLE_CYC + 1 cycles.
- **Code map (index 0..7):** 0001→0, 0011→1, 0010→2, 0110→3, 0100→4, 1100→5, 1000→6, 1001→7.
  - 0000 = idle: not an error; clears the index-valid flag.
  - Any other code = illegal: phase_err pulses and the index-valid flag is cleared.
- **Transition rules** (on acceptance of a valid code, new index n, previous index p):
  - Index-valid flag 0: load p <= n, set the flag; no step, no error.
  - n == p+1 mod 8: forward step. step_pulse=1, dir<=1.
  - n == p-1 mod 8: reverse step. step_pulse=1, dir<=0.
  - Any other n: phase_err=1, no step, p <= n (resync); dir holds.
- **Distance accumulation:**
  - Forward step with step_acc == STEPS_PER_UNIT-1: step_acc <= 0, dist_pulse=1, and dist_cnt increments unless already 16'hFFFF. dist_pulse still fires when dist_cnt is saturated.
  - Forward step otherwise: step_acc increments.
  - Reverse step: step_acc decrements, saturating at 0. It never borrows from dist_cnt.
- **clr_dist:** step_acc <= 0 and dist_cnt <= 0. If a step is accepted in the same cycle, clr_dist wins: no dist_pulse and the step is not accumulated, but step_pulse and dir still update.
- **moving:**
  - Any step_pulse sets moving=1 and zeroes the timeout counter.
  - Otherwise the counter increments while moving=1; when it reaches TIMEOUT, moving <= 0 and the counter holds at 0.
- **Pulse exclusivity:** step_pulse and phase_err are mutually exclusive in any cycle.
- **Reset mid-operation:** all state is cleared immediately. The first valid code after reset only re-acquires the index and is never counted.

Test Plan (sim params STABLE_CYC=2, STEPS_PER_UNIT=4, TIMEOUT=50):
1. After reset, drive 0001 then 0011, each held 10 cycles → no pulse for 0001 (acquire); one step_pulse with dir=1 for 0011, exactly 5 cycles after the 0011 edge.
2. Drive 8 forward codes, from 0001 to 1001, then 0001 again; hold each code 10 cycles → 8 step_pulses, dist_pulse after the 4th and 8th step, dist_cnt=2, step_acc=0.
3. Starting from acquired 0110, drive 0010 then 0011 → 2 step_pulses with dir=0; step_acc saturates at 0; dist_cnt unchanged.
4. Jump 0001→0100, then drive 0111 → phase_err pulses for each with no step_pulse; 0000 then 0001 → no pulses (re-acquire).
5. Insert a 1-cycle glitch 0011 within a steady 0001, and separately a 2-cycle glitch → neither is accepted, so no step_pulse and no phase_err.
6. Set step_acc=3, then drive a forward step coincident with clr_dist=1 → step_pulse=1, dist_pulse=0, dist_cnt=0. After 50 idle cycles → moving falls to 0. Assert sys_rst_n low mid-sequence → all outputs 0 immediately.
